// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// No logic of its own. Zero latency.
// No backpressure here: the state encoding is fixed so other blocks can decode it.
package serial_tx_pkg;

  // Frame sequencing states. PARITY is only reachable when the parity build option is enabled.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10,
    DONE   = 2'b11
  } state_t;

  // Level driven on the serial line whenever no frame bit is presented.
  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/serial_pattern_tx.sv
// Parallel-in, LSB-first serial-out transmitter with an end-of-frame done pulse.
// Latency: first bit appears 1 cycle after start is accepted; done follows the last transfer by 1 cycle.
// Backpressure: out_ready low freezes out, shift register and counter. Build option SERIAL_PATTERN_TX_PARITY_EN appends an even-parity bit.
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             out,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;

  // Sequencing and shift register update. Bits move out by rotating the word right,
  // so the register always holds a rotation of the loaded word. Its XOR reduction
  // is therefore still the parity of the loaded word when the last bit leaves.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        out_d       = IDLE_LEVEL;
        out_valid_d = 1'b0;
        if (start) begin
          shreg_d     = data;
          cnt_d       = '0;
          out_d       = data[0];
          out_valid_d = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (out_ready) begin
          if (cnt_q == LAST_IDX) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            out_d       = ^shreg_q;
            out_valid_d = 1'b1;
            state_d     = PARITY;
`else
            out_d       = IDLE_LEVEL;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = DONE;
`endif
          end else begin
            shreg_d = {shreg_q[0], shreg_q[WIDTH-1:1]};
            out_d   = shreg_q[1];
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      PARITY: begin
        if (out_ready) begin
          out_d       = IDLE_LEVEL;
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = DONE;
        end
      end
`endif
      DONE: begin
        out_d       = IDLE_LEVEL;
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        out_d       = IDLE_LEVEL;
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State register. Reset discards any partial frame without a done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      out_q       <= IDLE_LEVEL;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx (WIDTH=8). Stimulus pushes the expected bit stream.
// A negedge monitor pops one entry on every transfer and checks done after the frame's last bit.
// Define SERIAL_PATTERN_TX_PARITY_EN for both RTL and bench to exercise the parity bit.
module tb_serial_pattern_tx;

  localparam int WIDTH = 8;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] data;
  logic             ready;
  logic             out;
  logic             out_ready;
  logic             out_valid;
  logic             done;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   vld_cnt = 0;
  bit   exp_done = 1'b0;

  serial_pattern_tx #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data      (data),
    .ready     (ready),
    .out       (out),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) begin
      exp_t e;
      e.b    = w[i];
      e.last = (i == FL - 1);
      exp_q.push_back(e);
    end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    begin
      exp_t p;
      p.b    = ^w;
      p.last = 1'b1;
      exp_q.push_back(p);
    end
`endif
  endtask

  // Waits (bounded) for ready, issues a one-cycle start; returns in the first bit cycle.
  task automatic send(input logic [WIDTH-1:0] w);
    bit got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ready) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk("ready_before_start", {31'd0, got}, 32'd1);
    start = 1'b1;
    data  = w;
    push_frame(w);
    step();
    start = 1'b0;
  endtask

  // Returns in the cycle where done is high, or flags a timeout.
  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk("done_seen", {31'd0, got}, 32'd1);
  endtask

  // Monitor: a transfer happens at the next posedge when out_valid && out_ready now.
  always @(negedge clk) begin
    if (exp_done) begin
      chk("done_after_last", {31'd0, done}, 32'd1);
      exp_done = 1'b0;
    end else if (done) begin
      chk("spurious_done", {31'd0, done}, 32'd0);
    end
    if (out_valid) vld_cnt++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_bit", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("bit", {31'd0, out}, {31'd0, e.b});
        exp_done = e.last;
      end
    end
  end

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    data      = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_out", {31'd0, out}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    step();

    // Basic frame: bits in cycles 1..FL, done in FL+1, ready in FL+2.
    send(8'hA5);
    chk("basic_busy", {31'd0, ready}, 32'd0);
    chk("basic_valid_c1", {31'd0, out_valid}, 32'd1);
    repeat (FL - 1) step();
    chk("basic_valid_last", {31'd0, out_valid}, 32'd1);
    step();
    chk("basic_done_cycle", {31'd0, done}, 32'd1);
    chk("basic_not_ready_in_done", {31'd0, ready}, 32'd0);
    step();
    chk("basic_ready_after", {31'd0, ready}, 32'd1);
    chk("basic_done_cleared", {31'd0, done}, 32'd0);

    // Backpressure while bit index 2 is presented.
    vld_cnt = 0;
    send(8'hA5);
    step();
    step();
    out_ready = 1'b0;
    repeat (3) begin
      step();
      chk("stall_hold_out", {31'd0, out}, 32'd1);
      chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    wait_done();
    chk("stall_valid_cycles", vld_cnt, FL + 3);
    step();

    // Start while busy is ignored.
    send(8'hA5);
    repeat (3) step();
    start = 1'b1;
    data  = 8'hFF;
    chk("busy_ready_low", {31'd0, ready}, 32'd0);
    step();
    start = 1'b0;
    chk("busy_still_low", {31'd0, ready}, 32'd0);
    wait_done();
    step();
    chk("busy_ready_back", {31'd0, ready}, 32'd1);

    // Reset while bit 4 is presented.
    send(8'hA5);
    repeat (4) step();
    reset     = 1'b0;
    out_ready = 1'b0;
    step();
    chk("mrst_out", {31'd0, out}, 32'd0);
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_ready", {31'd0, ready}, 32'd1);
    reset     = 1'b1;
    out_ready = 1'b1;
    exp_q.delete();
    send(8'h3B);
    wait_done();
    step();

    // Back-to-back with start held high.
    start = 1'b1;
    data  = 8'h3C;
    push_frame(8'h3C);
    push_frame(8'hC3);
    step();
    data = 8'hC3;
    repeat (FL - 1) step();
    step();
    chk("b2b_done", {31'd0, done}, 32'd1);
    step();
    chk("b2b_gap_valid", {31'd0, out_valid}, 32'd0);
    chk("b2b_gap_ready", {31'd0, ready}, 32'd1);
    step();
    chk("b2b_restart", {31'd0, out_valid}, 32'd1);
    start = 1'b0;
    wait_done();
    step();

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    send(8'hA5);
    wait_done();
    step();
    send(8'h07);
    wait_done();
    step();
`endif

    repeat (3) step();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
